// File: rtl/debounced_step_control.sv
// ============================================================================
// Module   : debounced_step_control
// Brief    : Push-button synchronizer/debouncer with STEP/RUN datapath enable.
//            Optional auto-repeat in STEP mode when STEP_REPEAT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module debounced_step_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int RUN_DIV         = 50000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        BtnStep,
    input  logic        BtnMode,
    output logic        CpuEn,
    output logic        Mode,
    output logic [15:0] StepCount,
    output logic [1:0]  BtnLevel
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               RUN_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || RUN_DIV < 1 || REPEAT_CYCLES < 1 ||
            (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_check
            $error("debounced_step_control: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_STEP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [1:0] raw;
    logic [1:0] level;
    logic [1:0] level_d;
    logic [1:0] press;

    assign raw = {BtnMode, BtnStep};

    // Bit 0 = step, bit 1 = mode; each gets its own synchronizer and debouncer.
    generate
        for (genvar i = 0; i < 2; i++) begin : g_btn
            logic             s1;
            logic             s2;
            logic             lvl;
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    s1  <= 1'b0;
                    s2  <= 1'b0;
                    lvl <= 1'b0;
                    cnt <= '0;
                end else begin
                    s1 <= raw[i];
                    s2 <= s1;
                    if (s2 == lvl) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        lvl <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end

            assign level[i] = lvl;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            level_d <= 2'b00;
        end else begin
            level_d <= level;
        end
    end

    assign press    = level & ~level_d;
    assign BtnLevel = level;

    state_t           state;
    state_t           state_next;
    logic             cpu_en_next;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_next;

`ifdef STEP_REPEAT_EN
    localparam int               REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_next;
    logic             rep_arm;
    logic             rep_arm_next;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_STEP;
            CpuEn     <= 1'b0;
            run_cnt   <= '0;
            StepCount <= 16'h0000;
`ifdef STEP_REPEAT_EN
            rep_cnt   <= '0;
            rep_arm   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            CpuEn     <= cpu_en_next;
            run_cnt   <= run_cnt_next;
            StepCount <= StepCount + {15'd0, cpu_en_next};
`ifdef STEP_REPEAT_EN
            rep_cnt   <= rep_cnt_next;
            rep_arm   <= rep_arm_next;
`endif
        end
    end

    assign Mode = (state == ST_RUN);

    always_comb begin
        state_next   = state;
        cpu_en_next  = 1'b0;
        run_cnt_next = '0;
`ifdef STEP_REPEAT_EN
        rep_cnt_next = '0;
        rep_arm_next = 1'b0;
`endif
        case (state)
            ST_STEP: begin
                // A mode press wins over a coincident step press.
                if (press[1]) begin
                    state_next = ST_RUN;
                end else if (press[0]) begin
                    cpu_en_next = 1'b1;
`ifdef STEP_REPEAT_EN
                    rep_arm_next = 1'b1;
                end else if (rep_arm && level[0]) begin
                    rep_arm_next = 1'b1;
                    if (rep_cnt == REP_LAST) begin
                        cpu_en_next = 1'b1;
                    end else begin
                        rep_cnt_next = rep_cnt + REP_W'(1);
                    end
`endif
                end
            end
            ST_RUN: begin
                if (press[1]) begin
                    state_next = ST_STEP;
                end else if (run_cnt == RUN_LAST) begin
                    cpu_en_next = 1'b1;
                end else begin
                    run_cnt_next = run_cnt + RUN_W'(1);
                end
            end
            default: begin
                state_next = ST_STEP;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_debounced_step_control.sv
// Testbench for debounced_step_control: vector table plus pulse scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_debounced_step_control;

    localparam int DB  = 4;
    localparam int RD  = 8;
    localparam int RP  = 6;
    localparam int LAT = DB + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step, btn_mode;
    logic        cpu_en, mode;
    logic [15:0] step_count;
    logic [1:0]  btn_level;
    logic        btn_step2, btn_mode2;
    logic        cpu_en2, mode2;
    logic [15:0] step_count2;
    logic [1:0]  btn_level2;

    always #5 clk = ~clk;

    debounced_step_control #(
        .DEBOUNCE_CYCLES(DB), .CNT_W(3), .RUN_DIV(RD), .REPEAT_CYCLES(RP)
    ) dut (
        .Clk(clk), .Reset(rst), .BtnStep(btn_step), .BtnMode(btn_mode),
        .CpuEn(cpu_en), .Mode(mode), .StepCount(step_count), .BtnLevel(btn_level)
    );

    debounced_step_control #(
        .DEBOUNCE_CYCLES(DB), .CNT_W(3), .RUN_DIV(1), .REPEAT_CYCLES(RP)
    ) dut_fast (
        .Clk(clk), .Reset(rst), .BtnStep(btn_step2), .BtnMode(btn_mode2),
        .CpuEn(cpu_en2), .Mode(mode2), .StepCount(step_count2), .BtnLevel(btn_level2)
    );

    typedef struct {
        int pre;
        int hold;
        bit exp_pulse;
    } vec_t;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_checks = 0;
    int   exp_q[$];
    int   exp_count = 0;
    logic prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, exp);
    endfunction

    function automatic void push_pulse(input int t);
        exp_q.push_back(t);
        exp_count++;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every CpuEn pulse must match the next scheduled cycle in the scoreboard.
    always @(negedge clk) begin
        if (cpu_en) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", cpu_en, 0);
            else                   chk("pulse_cycle", cyc, exp_q.pop_front());
            chk("pulse_width", prev_en, 0);
        end
        prev_en = cpu_en;
    end

    initial begin
        vec_t vecs[6];
        int   c;
        int   c2;
        logic seen;
        int   n;

        vecs[0] = '{pre: 0, hold: 1, exp_pulse: 1'b0};
        vecs[1] = '{pre: 0, hold: 3, exp_pulse: 1'b0};
        vecs[2] = '{pre: 0, hold: 4, exp_pulse: 1'b1};
        vecs[3] = '{pre: 3, hold: 3, exp_pulse: 1'b0};
        vecs[4] = '{pre: 3, hold: 5, exp_pulse: 1'b1};
        vecs[5] = '{pre: 0, hold: 6, exp_pulse: 1'b1};

        rst = 1'b1; btn_step = 1'b1; btn_mode = 1'b1;
        btn_step2 = 1'b0; btn_mode2 = 1'b0;

        // Reset held with both buttons high
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_cpu_en", cpu_en, 0);
            chk("reset_mode", mode, 0);
            chk("reset_step_count", step_count, 0);
            chk("reset_btn_level", btn_level, 0);
        end

        // Release reset with step still held: one pulse, latency from release
        rst = 1'b0; btn_mode = 1'b0; c = cyc;
        push_pulse(c + LAT);
`ifdef STEP_REPEAT_EN
        push_pulse(c + LAT + 6);
        push_pulse(c + LAT + 12);
        push_pulse(c + LAT + 18);
`endif
        idle(20);
        btn_step = 1'b0;
        idle(15);
        chk("held_step_count", step_count, exp_count);
        chk("held_btn_level", btn_level, 0);
        chk("held_pending", exp_q.size(), 0);

        // Table of step presses: short glitches, bounces and clean presses
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].pre > 0) begin
                btn_step = 1'b1; idle(vecs[v].pre);
                btn_step = 1'b0; idle(1);
            end
            btn_step = 1'b1; c = cyc;
            if (vecs[v].exp_pulse) push_pulse(c + LAT);
            seen = 1'b0;
            for (int k = 0; k < vecs[v].hold; k++) begin
                idle(1); seen |= btn_level[0];
            end
            btn_step = 1'b0;
            for (int k = 0; k < 14; k++) begin
                idle(1); seen |= btn_level[0];
            end
            chk("vec_level_seen", seen, vecs[v].exp_pulse);
            chk("vec_step_count", step_count, exp_count);
            chk("vec_pending", exp_q.size(), 0);
        end

        // RUN mode: pulses every RD cycles, step ignored, exit suppresses a due pulse
        c = cyc;
        push_pulse(c + 15); push_pulse(c + 23); push_pulse(c + 31); push_pulse(c + 39);
        for (int k = 0; k < 60; k++) begin
            if (k == 6)  chk("run_mode_before", mode, 0);
            if (k == 7)  chk("run_mode_after", mode, 1);
            if (k == 46) chk("exit_mode_before", mode, 1);
            if (k == 47) chk("exit_mode_after", mode, 0);
            btn_mode = (k < 6) || (k >= 40 && k < 46);
            btn_step = (k >= 20 && k < 26);
            @(negedge clk);
        end
        chk("run_pending", exp_q.size(), 0);
        chk("run_step_count", step_count, exp_count);

        // Both buttons together in STEP: mode wins, no pulse
        btn_step = 1'b1; btn_mode = 1'b1;
        idle(6);
        btn_step = 1'b0; btn_mode = 1'b0;
        chk("both_mode_before", mode, 0);
        idle(1);
        chk("both_mode_after", mode, 1);
        chk("both_cpu_en", cpu_en, 0);
        rst = 1'b1; idle(2); rst = 1'b0;
        exp_count = 0;
        chk("rerst_mode", mode, 0);
        chk("rerst_step_count", step_count, 0);

        // Reset while the step debounce count is 2 discards the progress
        idle(2);
        btn_step = 1'b1;
        idle(4);
        rst = 1'b1; idle(1); rst = 1'b0; c2 = cyc;
        push_pulse(c2 + LAT);
        chk("middb_btn_level", btn_level, 0);
        idle(6);
        btn_step = 1'b0;
        idle(14);
        chk("middb_pending", exp_q.size(), 0);
        chk("middb_step_count", step_count, 1);

`ifdef STEP_REPEAT_EN
        btn_step = 1'b1; c = cyc;
        push_pulse(c + LAT); push_pulse(c + LAT + 6); push_pulse(c + LAT + 12);
        idle(17);
        btn_step = 1'b0;
        idle(14);
        chk("repeat_pending", exp_q.size(), 0);
        chk("repeat_step_count", step_count, exp_count);
`endif

        // RUN_DIV=1: continuous pulses, StepCount wraps through 0xFFFF
        btn_mode2 = 1'b1; c = cyc;
        idle(6);
        btn_mode2 = 1'b0;
        idle(1);
        chk("fast_mode", mode2, 1);
        n = 0;
        while (step_count2 != 16'hFFFF && n < 70000) begin
            idle(1); n++;
        end
        chk("wrap_reach", step_count2, 16'hFFFF);
        chk("wrap_cycle", cyc, c + 8 + 65534);
        idle(1);
        chk("wrap_zero", step_count2, 16'h0000);
        chk("wrap_cpu_en", cpu_en2, 1);
        idle(1);
        chk("wrap_one", step_count2, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
